axi_master_arbiter: RTL and testbench

- Shares the single SoC AXI4 master port between two system masters: s0 is the host master (JTAG2AXI or XDMA path), s1 is a secondary master such as a debug or boot DMA.
- Sits between the sys master block and the main crossbar.
- Arbitrates the write and read directions independently, each with round-robin grant.
- Allows one outstanding transaction per direction and holds the grant until that transaction completes.

---
 rtl/axi_master_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
//   Shares one AXI4 master port between two upstream masters (s0 = host,
//   s1 = secondary/debug DMA). Write and read directions are arbitrated
//   independently, round-robin on ties, one outstanding transaction per
//   direction, with the grant held until that transaction completes.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   s0_axi_*, s1_axi_*    AXI4 slave bundles (AW, W, B, AR, R)
//   m_axi_*               AXI4 master bundle toward the crossbar
//   wr_grant_o            one-hot write owner, 00 when idle
//   rd_grant_o            one-hot read owner, 00 when idle
module axi_master_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   // s0
   input  logic [ID_WIDTH-1:0]       s0_axi_awid,     input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
   input  logic [7:0]                s0_axi_awlen,    input  logic [2:0]            s0_axi_awsize,
   input  logic [1:0]                s0_axi_awburst,  input  logic                  s0_axi_awlock,
   input  logic [3:0]                s0_axi_awcache,  input  logic [2:0]            s0_axi_awprot,
   input  logic [3:0]                s0_axi_awqos,    input  logic [3:0]            s0_axi_awregion,
   input  logic                      s0_axi_awvalid,  output logic                  s0_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
   input  logic                      s0_axi_wlast,    input  logic                  s0_axi_wvalid,
   output logic                      s0_axi_wready,
   output logic [ID_WIDTH-1:0]       s0_axi_bid,      output logic [1:0]            s0_axi_bresp,
   output logic                      s0_axi_bvalid,   input  logic                  s0_axi_bready,
   input  logic [ID_WIDTH-1:0]       s0_axi_arid,     input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
   input  logic [7:0]                s0_axi_arlen,    input  logic [2:0]            s0_axi_arsize,
   input  logic [1:0]                s0_axi_arburst,  input  logic                  s0_axi_arlock,
   input  logic [3:0]                s0_axi_arcache,  input  logic [2:0]            s0_axi_arprot,
   input  logic [3:0]                s0_axi_arqos,    input  logic [3:0]            s0_axi_arregion,
   input  logic                      s0_axi_arvalid,  output logic                  s0_axi_arready,
   output logic [ID_WIDTH-1:0]       s0_axi_rid,      output logic [DATA_WIDTH-1:0] s0_axi_rdata,
   output logic [1:0]                s0_axi_rresp,    output logic                  s0_axi_rlast,
   output logic                      s0_axi_rvalid,   input  logic                  s0_axi_rready,
   // s1
   input  logic [ID_WIDTH-1:0]       s1_axi_awid,     input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
   input  logic [7:0]                s1_axi_awlen,    input  logic [2:0]            s1_axi_awsize,
   input  logic [1:0]                s1_axi_awburst,  input  logic                  s1_axi_awlock,
   input  logic [3:0]                s1_axi_awcache,  input  logic [2:0]            s1_axi_awprot,
   input  logic [3:0]                s1_axi_awqos,    input  logic [3:0]            s1_axi_awregion,
   input  logic                      s1_axi_awvalid,  output logic                  s1_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
   input  logic                      s1_axi_wlast,    input  logic                  s1_axi_wvalid,
   output logic                      s1_axi_wready,
   output logic [ID_WIDTH-1:0]       s1_axi_bid,      output logic [1:0]            s1_axi_bresp,
   output logic                      s1_axi_bvalid,   input  logic                  s1_axi_bready,
   input  logic [ID_WIDTH-1:0]       s1_axi_arid,     input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
   input  logic [7:0]                s1_axi_arlen,    input  logic [2:0]            s1_axi_arsize,
   input  logic [1:0]                s1_axi_arburst,  input  logic                  s1_axi_arlock,
   input  logic [3:0]                s1_axi_arcache,  input  logic [2:0]            s1_axi_arprot,
   input  logic [3:0]                s1_axi_arqos,    input  logic [3:0]            s1_axi_arregion,
   input  logic                      s1_axi_arvalid,  output logic                  s1_axi_arready,
   output logic [ID_WIDTH-1:0]       s1_axi_rid,      output logic [DATA_WIDTH-1:0] s1_axi_rdata,
   output logic [1:0]                s1_axi_rresp,    output logic                  s1_axi_rlast,
   output logic                      s1_axi_rvalid,   input  logic                  s1_axi_rready,
   // m
   output logic [ID_WIDTH-1:0]       m_axi_awid,      output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,     output logic [2:0]            m_axi_awsize,
   output logic [1:0]                m_axi_awburst,   output logic                  m_axi_awlock,
   output logic [3:0]                m_axi_awcache,   output logic [2:0]            m_axi_awprot,
   output logic [3:0]                m_axi_awqos,     output logic [3:0]            m_axi_awregion,
   output logic                      m_axi_awvalid,   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,     output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                      m_axi_wlast,     output logic                  m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [ID_WIDTH-1:0]       m_axi_bid,       input  logic [1:0]            m_axi_bresp,
   input  logic                      m_axi_bvalid,    output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]       m_axi_arid,      output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                m_axi_arlen,     output logic [2:0]            m_axi_arsize,
   output logic [1:0]                m_axi_arburst,   output logic                  m_axi_arlock,
   output logic [3:0]                m_axi_arcache,   output logic [2:0]            m_axi_arprot,
   output logic [3:0]                m_axi_arqos,     output logic [3:0]            m_axi_arregion,
   output logic                      m_axi_arvalid,   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]       m_axi_rid,       input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,     input  logic                  m_axi_rlast,
   input  logic                      m_axi_rvalid,    output logic                  m_axi_rready,
   // grant status
   output logic [1:0]                wr_grant_o,
   output logic [1:0]                rd_grant_o
);

   localparam int AXW = ID_WIDTH + ADDR_WIDTH + 29;
   localparam int WW  = DATA_WIDTH + DATA_WIDTH/8 + 1;
   localparam int RW  = ID_WIDTH + DATA_WIDTH + 3;
   localparam int BW  = ID_WIDTH + 2;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

   wr_state_t  r_wst;
   rd_state_t  r_rst;
   logic       r_wsel, r_rsel;   // current owner: 0 = s0, 1 = s1
   logic       r_wptr, r_rptr;   // last completed owner; reset to 1 so s0 wins the first tie
   logic [1:0] r_wr_grant, r_rd_grant;
   logic       w_wpick, w_rpick;

   logic [AXW-1:0] w_s0_aw, w_s1_aw, w_m_aw, w_s0_ar, w_s1_ar, w_m_ar;
   logic [WW-1:0]  w_m_w;

   assign w_s0_aw = {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst,
                     s0_axi_awlock, s0_axi_awcache, s0_axi_awprot, s0_axi_awqos, s0_axi_awregion};
   assign w_s1_aw = {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst,
                     s1_axi_awlock, s1_axi_awcache, s1_axi_awprot, s1_axi_awqos, s1_axi_awregion};
   assign w_s0_ar = {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst,
                     s0_axi_arlock, s0_axi_arcache, s0_axi_arprot, s0_axi_arqos, s0_axi_arregion};
   assign w_s1_ar = {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst,
                     s1_axi_arlock, s1_axi_arcache, s1_axi_arprot, s1_axi_arqos, s1_axi_arregion};

   assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion} = w_m_aw;
   assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion} = w_m_ar;
   assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_m_w;

   // On a tie pick the master that did not complete last; otherwise whoever requests.
   assign w_wpick = (s0_axi_awvalid && s1_axi_awvalid) ? ~r_wptr : s1_axi_awvalid;
   assign w_rpick = (s0_axi_arvalid && s1_axi_arvalid) ? ~r_rptr : s1_axi_arvalid;

   assign wr_grant_o = r_wr_grant;
   assign rd_grant_o = r_rd_grant;

   // Write FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wst      <= W_IDLE;
         r_wsel     <= 1'b0;
         r_wptr     <= 1'b1;
         r_wr_grant <= '0;
      end else begin
         case (r_wst)
            W_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
               r_wsel     <= w_wpick;
               r_wr_grant <= w_wpick ? 2'b10 : 2'b01;
               r_wst      <= W_ADDR;
            end
            W_ADDR: if (m_axi_awvalid && m_axi_awready) r_wst <= W_DATA;
            W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) r_wst <= W_RESP;
            W_RESP: if (m_axi_bvalid && m_axi_bready) begin
               r_wptr     <= r_wsel;
               r_wr_grant <= '0;
               r_wst      <= W_IDLE;
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   // Read FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rst      <= R_IDLE;
         r_rsel     <= 1'b0;
         r_rptr     <= 1'b1;
         r_rd_grant <= '0;
      end else begin
         case (r_rst)
            R_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
               r_rsel     <= w_rpick;
               r_rd_grant <= w_rpick ? 2'b10 : 2'b01;
               r_rst      <= R_ADDR;
            end
            R_ADDR: if (m_axi_arvalid && m_axi_arready) r_rst <= R_DATA;
            R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
               r_rptr     <= r_rsel;
               r_rd_grant <= '0;
               r_rst      <= R_IDLE;
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end

   // Write-side routing; everything idles at 0 outside the owning phase.
   always_comb begin
      w_m_aw = '0;  m_axi_awvalid = 1'b0;  s0_axi_awready = 1'b0;  s1_axi_awready = 1'b0;
      w_m_w  = '0;  m_axi_wvalid  = 1'b0;  s0_axi_wready  = 1'b0;  s1_axi_wready  = 1'b0;
      m_axi_bready = 1'b0;  s0_axi_bvalid = 1'b0;  s1_axi_bvalid = 1'b0;
      {s0_axi_bid, s0_axi_bresp} = {BW{1'b0}};
      {s1_axi_bid, s1_axi_bresp} = {BW{1'b0}};
      case (r_wst)
         W_ADDR: begin
            w_m_aw         = r_wsel ? w_s1_aw : w_s0_aw;
            m_axi_awvalid  = r_wsel ? s1_axi_awvalid : s0_axi_awvalid;
            s0_axi_awready = ~r_wsel & m_axi_awready;
            s1_axi_awready =  r_wsel & m_axi_awready;
         end
         W_DATA: begin
            w_m_w         = r_wsel ? {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast}
                                   : {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast};
            m_axi_wvalid  = r_wsel ? s1_axi_wvalid : s0_axi_wvalid;
            s0_axi_wready = ~r_wsel & m_axi_wready;
            s1_axi_wready =  r_wsel & m_axi_wready;
         end
         W_RESP: begin
            m_axi_bready = r_wsel ? s1_axi_bready : s0_axi_bready;
            if (r_wsel) begin
               s1_axi_bvalid = m_axi_bvalid;
               {s1_axi_bid, s1_axi_bresp} = {m_axi_bid, m_axi_bresp};
            end else begin
               s0_axi_bvalid = m_axi_bvalid;
               {s0_axi_bid, s0_axi_bresp} = {m_axi_bid, m_axi_bresp};
            end
         end
         default: ;
      endcase
   end

   // Read-side routing
   always_comb begin
      w_m_ar = '0;  m_axi_arvalid = 1'b0;  s0_axi_arready = 1'b0;  s1_axi_arready = 1'b0;
      m_axi_rready = 1'b0;  s0_axi_rvalid = 1'b0;  s1_axi_rvalid = 1'b0;
      {s0_axi_rid, s0_axi_rdata, s0_axi_rresp, s0_axi_rlast} = {RW{1'b0}};
      {s1_axi_rid, s1_axi_rdata, s1_axi_rresp, s1_axi_rlast} = {RW{1'b0}};
      case (r_rst)
         R_ADDR: begin
            w_m_ar         = r_rsel ? w_s1_ar : w_s0_ar;
            m_axi_arvalid  = r_rsel ? s1_axi_arvalid : s0_axi_arvalid;
            s0_axi_arready = ~r_rsel & m_axi_arready;
            s1_axi_arready =  r_rsel & m_axi_arready;
         end
         R_DATA: begin
            m_axi_rready = r_rsel ? s1_axi_rready : s0_axi_rready;
            if (r_rsel) begin
               s1_axi_rvalid = m_axi_rvalid;
               {s1_axi_rid, s1_axi_rdata, s1_axi_rresp, s1_axi_rlast} =
                  {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
            end else begin
               s0_axi_rvalid = m_axi_rvalid;
               {s0_axi_rid, s0_axi_rdata, s0_axi_rresp, s0_axi_rlast} =
                  {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb_axi_master_arbiter
//   Directed bench for axi_master_arbiter: single write, write tie-break
//   round-robin, concurrent read/write, throttled 8-beat write, mid-burst
//   reset and a stalled B response.
module tb_axi_master_arbiter;

   logic clk_i, rst_ni;

   logic [1:0]  s0_axi_awid, s0_axi_awburst, s0_axi_bid, s0_axi_bresp, s0_axi_arid, s0_axi_arburst, s0_axi_rid, s0_axi_rresp;
   logic [31:0] s0_axi_awaddr, s0_axi_wdata, s0_axi_araddr, s0_axi_rdata;
   logic [7:0]  s0_axi_awlen, s0_axi_arlen;
   logic [2:0]  s0_axi_awsize, s0_axi_awprot, s0_axi_arsize, s0_axi_arprot;
   logic [3:0]  s0_axi_awcache, s0_axi_awqos, s0_axi_awregion, s0_axi_wstrb, s0_axi_arcache, s0_axi_arqos, s0_axi_arregion;
   logic        s0_axi_awlock, s0_axi_awvalid, s0_axi_awready, s0_axi_wlast, s0_axi_wvalid, s0_axi_wready;
   logic        s0_axi_bvalid, s0_axi_bready, s0_axi_arlock, s0_axi_arvalid, s0_axi_arready;
   logic        s0_axi_rlast, s0_axi_rvalid, s0_axi_rready;

   logic [1:0]  s1_axi_awid, s1_axi_awburst, s1_axi_bid, s1_axi_bresp, s1_axi_arid, s1_axi_arburst, s1_axi_rid, s1_axi_rresp;
   logic [31:0] s1_axi_awaddr, s1_axi_wdata, s1_axi_araddr, s1_axi_rdata;
   logic [7:0]  s1_axi_awlen, s1_axi_arlen;
   logic [2:0]  s1_axi_awsize, s1_axi_awprot, s1_axi_arsize, s1_axi_arprot;
   logic [3:0]  s1_axi_awcache, s1_axi_awqos, s1_axi_awregion, s1_axi_wstrb, s1_axi_arcache, s1_axi_arqos, s1_axi_arregion;
   logic        s1_axi_awlock, s1_axi_awvalid, s1_axi_awready, s1_axi_wlast, s1_axi_wvalid, s1_axi_wready;
   logic        s1_axi_bvalid, s1_axi_bready, s1_axi_arlock, s1_axi_arvalid, s1_axi_arready;
   logic        s1_axi_rlast, s1_axi_rvalid, s1_axi_rready;

   logic [1:0]  m_axi_awid, m_axi_awburst, m_axi_bid, m_axi_bresp, m_axi_arid, m_axi_arburst, m_axi_rid, m_axi_rresp;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
   logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_wstrb, m_axi_arcache, m_axi_arqos, m_axi_arregion;
   logic        m_axi_awlock, m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arlock, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   logic [1:0]  wr_grant_o, rd_grant_o;

   int n_pass  = 0;
   int n_total = 0;

   axi_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen), .s0_axi_awsize(s0_axi_awsize),
      .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock), .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot),
      .s0_axi_awqos(s0_axi_awqos), .s0_axi_awregion(s0_axi_awregion), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
      .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
      .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready),
      .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize),
      .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock), .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot),
      .s0_axi_arqos(s0_axi_arqos), .s0_axi_arregion(s0_axi_arregion), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
      .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rlast(s0_axi_rlast),
      .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
      .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen), .s1_axi_awsize(s1_axi_awsize),
      .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock), .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot),
      .s1_axi_awqos(s1_axi_awqos), .s1_axi_awregion(s1_axi_awregion), .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
      .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
      .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready),
      .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize),
      .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock), .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot),
      .s1_axi_arqos(s1_axi_arqos), .s1_axi_arregion(s1_axi_arregion), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
      .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rlast(s1_axi_rlast),
      .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .wr_grant_o(wr_grant_o), .rd_grant_o(rd_grant_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_aw(input bit sel, input logic v, input logic [31:0] addr, input logic [1:0] id, input logic [7:0] len);
      if (!sel) begin s0_axi_awvalid = v; s0_axi_awaddr = addr; s0_axi_awid = id; s0_axi_awlen = len; end
      else      begin s1_axi_awvalid = v; s1_axi_awaddr = addr; s1_axi_awid = id; s1_axi_awlen = len; end
   endtask

   task automatic set_ar(input bit sel, input logic v, input logic [31:0] addr, input logic [1:0] id, input logic [7:0] len);
      if (!sel) begin s0_axi_arvalid = v; s0_axi_araddr = addr; s0_axi_arid = id; s0_axi_arlen = len; end
      else      begin s1_axi_arvalid = v; s1_axi_araddr = addr; s1_axi_arid = id; s1_axi_arlen = len; end
   endtask

   task automatic set_w(input bit sel, input logic v, input logic [31:0] data, input logic last);
      if (!sel) begin s0_axi_wvalid = v; s0_axi_wdata = data; s0_axi_wlast = last; end
      else      begin s1_axi_wvalid = v; s1_axi_wdata = data; s1_axi_wlast = last; end
   endtask

   task automatic set_bready(input bit sel, input logic v);
      if (!sel) s0_axi_bready = v; else s1_axi_bready = v;
   endtask

   // Entered with sel owning the write in W_ADDR and its awvalid high;
   // drives one data beat and an OKAY response, returns in W_IDLE.
   task automatic wr_single(input bit sel, input logic [1:0] id, input logic [31:0] data);
      chk("ws_awvalid", m_axi_awvalid, 1'b1);
      tick();
      set_aw(sel, 1'b0, 32'h0, 2'd0, 8'd0);
      set_w(sel, 1'b1, data, 1'b1);
      m_axi_wready = 1'b1;
      #1 chk("ws_wdata", m_axi_wdata, data);
      tick();
      set_w(sel, 1'b0, 32'h0, 1'b0);
      m_axi_bvalid = 1'b1; m_axi_bid = id; m_axi_bresp = 2'b00;
      set_bready(sel, 1'b1);
      #1;
      chk("ws_bvalid", sel ? s1_axi_bvalid : s0_axi_bvalid, 1'b1);
      chk("ws_bid", sel ? s1_axi_bid : s0_axi_bid, id);
      tick();
      m_axi_bvalid = 1'b0;
      set_bready(sel, 1'b0);
      m_axi_wready = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      int  beat, cyc;
      bit  hs;

      {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awlock, s0_axi_awcache, s0_axi_awqos, s0_axi_awregion} = '0;
      {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arlock, s0_axi_arcache, s0_axi_arqos, s0_axi_arregion} = '0;
      {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awlock, s1_axi_awcache, s1_axi_awqos, s1_axi_awregion} = '0;
      {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arlock, s1_axi_arcache, s1_axi_arqos, s1_axi_arregion} = '0;
      s0_axi_awsize = 3'd2; s0_axi_awburst = 2'b01; s0_axi_awprot = '0; s0_axi_arsize = 3'd2; s0_axi_arburst = 2'b01; s0_axi_arprot = '0;
      s1_axi_awsize = 3'd2; s1_axi_awburst = 2'b01; s1_axi_awprot = '0; s1_axi_arsize = 3'd2; s1_axi_arburst = 2'b01; s1_axi_arprot = '0;
      {s0_axi_awvalid, s0_axi_wvalid, s0_axi_wlast, s0_axi_bready, s0_axi_arvalid, s0_axi_rready} = '0;
      {s1_axi_awvalid, s1_axi_wvalid, s1_axi_wlast, s1_axi_bready, s1_axi_arvalid, s1_axi_rready} = '0;
      s0_axi_wdata = '0; s0_axi_wstrb = 4'hF; s1_axi_wdata = '0; s1_axi_wstrb = 4'hF;
      {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
      m_axi_bid = '0; m_axi_bresp = '0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;

      // reset state
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #1;
      chk("rst_wr_grant", wr_grant_o, 2'b00);
      chk("rst_rd_grant", rd_grant_o, 2'b00);
      chk("rst_m_awvalid", m_axi_awvalid, 1'b0);
      chk("rst_m_arvalid", m_axi_arvalid, 1'b0);
      chk("rst_m_bready", m_axi_bready, 1'b0);
      chk("rst_m_rready", m_axi_rready, 1'b0);
      chk("rst_m_awaddr", m_axi_awaddr, 32'h0);
      chk("rst_s0_awready", s0_axi_awready, 1'b0);
      tick(); tick();
      rst_ni = 1'b1;
      tick();

      // 1: single-beat write from s0
      set_aw(0, 1'b1, 32'h1000, 2'd2, 8'd0);
      m_axi_awready = 1'b1;
      #1;
      chk("t1_idle_no_fwd", m_axi_awvalid, 1'b0);
      chk("t1_idle_no_ready", s0_axi_awready, 1'b0);
      chk("t1_idle_grant", wr_grant_o, 2'b00);
      tick();
      set_w(0, 1'b1, 32'hDEADBEEF, 1'b1);
      m_axi_wready = 1'b1;
      #1;
      chk("t1_grant", wr_grant_o, 2'b01);
      chk("t1_m_awvalid", m_axi_awvalid, 1'b1);
      chk("t1_m_awaddr", m_axi_awaddr, 32'h1000);
      chk("t1_m_awid", m_axi_awid, 2'd2);
      chk("t1_s0_awready", s0_axi_awready, 1'b1);
      chk("t1_s1_awready", s1_axi_awready, 1'b0);
      chk("t1_no_w_before_aw", s0_axi_wready, 1'b0);
      chk("t1_m_wvalid_addr", m_axi_wvalid, 1'b0);
      tick();
      set_aw(0, 1'b0, 32'h0, 2'd0, 8'd0);
      #1;
      chk("t1_m_wvalid", m_axi_wvalid, 1'b1);
      chk("t1_m_wdata", m_axi_wdata, 32'hDEADBEEF);
      chk("t1_m_wlast", m_axi_wlast, 1'b1);
      chk("t1_s0_wready", s0_axi_wready, 1'b1);
      chk("t1_s1_wready", s1_axi_wready, 1'b0);
      chk("t1_bready_early", m_axi_bready, 1'b0);
      tick();
      set_w(0, 1'b0, 32'h0, 1'b0);
      m_axi_bvalid = 1'b1; m_axi_bid = 2'd2; m_axi_bresp = 2'b00;
      s0_axi_bready = 1'b1;
      #1;
      chk("t1_s0_bvalid", s0_axi_bvalid, 1'b1);
      chk("t1_s0_bid", s0_axi_bid, 2'd2);
      chk("t1_s0_bresp", s0_axi_bresp, 2'b00);
      chk("t1_m_bready", m_axi_bready, 1'b1);
      chk("t1_s1_bvalid", s1_axi_bvalid, 1'b0);
      tick();
      m_axi_bvalid = 1'b0; s0_axi_bready = 1'b0; m_axi_wready = 1'b0;
      #1 chk("t1_grant_done", wr_grant_o, 2'b00);

      // 2: simultaneous AW requests right after reset, twice
      do_reset();
      set_aw(0, 1'b1, 32'h2000, 2'd0, 8'd0);
      set_aw(1, 1'b1, 32'h3000, 2'd1, 8'd0);
      m_axi_awready = 1'b1;
      tick();
      #1;
      chk("t2_first_grant", wr_grant_o, 2'b01);
      chk("t2_first_addr", m_axi_awaddr, 32'h2000);
      wr_single(0, 2'd0, 32'h11111111);
      #1 chk("t2_idle_gap", wr_grant_o, 2'b00);
      tick();
      #1;
      chk("t2_second_grant", wr_grant_o, 2'b10);
      chk("t2_second_addr", m_axi_awaddr, 32'h3000);
      chk("t2_s0_awready_off", s0_axi_awready, 1'b0);
      chk("t2_s1_awready", s1_axi_awready, 1'b1);
      wr_single(1, 2'd1, 32'h22222222);
      set_aw(0, 1'b1, 32'h2004, 2'd0, 8'd0);
      set_aw(1, 1'b1, 32'h3004, 2'd1, 8'd0);
      tick();
      #1 chk("t2_repeat_first", wr_grant_o, 2'b01);
      wr_single(0, 2'd0, 32'h33333333);
      tick();
      #1 chk("t2_repeat_second", wr_grant_o, 2'b10);
      wr_single(1, 2'd1, 32'h44444444);

      // 3: s0 4-beat read concurrent with s1 2-beat write
      set_ar(0, 1'b1, 32'h4000, 2'd0, 8'd3);
      m_axi_arready = 1'b1;
      set_aw(1, 1'b1, 32'h5000, 2'd1, 8'd1);
      m_axi_awready = 1'b1;
      tick();
      #1;
      chk("t3_rd_grant", rd_grant_o, 2'b01);
      chk("t3_wr_grant", wr_grant_o, 2'b10);
      chk("t3_m_arlen", m_axi_arlen, 8'd3);
      chk("t3_m_araddr", m_axi_araddr, 32'h4000);
      tick();
      set_ar(0, 1'b0, 32'h0, 2'd0, 8'd0);
      set_aw(1, 1'b0, 32'h0, 2'd0, 8'd0);
      s0_axi_rready = 1'b1;
      m_axi_wready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rid = 2'd0; m_axi_rdata = 32'hA0 + i; m_axi_rlast = (i == 3);
         if (i < 2) set_w(1, 1'b1, 32'hB0 + i, i == 1);
         else       set_w(1, 1'b0, 32'h0, 1'b0);
         m_axi_bvalid = (i == 2); m_axi_bid = 2'd1; s1_axi_bready = (i == 2);
         #1;
         chk("t3_s0_rvalid", s0_axi_rvalid, 1'b1);
         chk("t3_s0_rdata", s0_axi_rdata, 32'hA0 + i);
         chk("t3_s0_rlast", s0_axi_rlast, i == 3);
         chk("t3_s1_rvalid", s1_axi_rvalid, 1'b0);
         chk("t3_rd_grant_hold", rd_grant_o, 2'b01);
         if (i < 2) begin
            chk("t3_m_wdata", m_axi_wdata, 32'hB0 + i);
            chk("t3_wr_grant_hold", wr_grant_o, 2'b10);
         end
         if (i == 2) chk("t3_s1_bvalid", s1_axi_bvalid, 1'b1);
         if (i == 3) chk("t3_wr_done", wr_grant_o, 2'b00);
         tick();
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0;
      m_axi_bvalid = 1'b0; s1_axi_bready = 1'b0; m_axi_wready = 1'b0;
      #1 chk("t3_rd_done", rd_grant_o, 2'b00);

      // 4: 8-beat write from s1 with m_wready toggling
      set_aw(1, 1'b1, 32'h6000, 2'd2, 8'd7);
      tick();
      #1;
      chk("t4_grant", wr_grant_o, 2'b10);
      chk("t4_m_awlen", m_axi_awlen, 8'd7);
      tick();
      set_aw(1, 1'b0, 32'h0, 2'd0, 8'd0);
      beat = 0;
      cyc  = 0;
      while (beat < 8 && cyc < 40) begin
         m_axi_wready = cyc[0];
         set_w(1, 1'b1, 32'hC0 + beat, beat == 7);
         #1;
         chk("t4_in_data", m_axi_wvalid, 1'b1);
         hs = m_axi_wvalid && m_axi_wready;
         if (hs) chk("t4_wdata", m_axi_wdata, 32'hC0 + beat);
         tick();
         if (hs) beat++;
         cyc++;
      end
      set_w(1, 1'b0, 32'h0, 1'b0);
      m_axi_wready = 1'b0;
      chk("t4_beats", beat, 8);
      chk("t4_cycles", cyc, 16);
      m_axi_bvalid = 1'b1; m_axi_bid = 2'd2; s1_axi_bready = 1'b1;
      #1;
      chk("t4_s1_bvalid", s1_axi_bvalid, 1'b1);
      chk("t4_m_bready", m_axi_bready, 1'b1);
      tick();
      m_axi_bvalid = 1'b0; s1_axi_bready = 1'b0;
      #1 chk("t4_done", wr_grant_o, 2'b00);

      // 5: reset asserted during beat 2 of a 4-beat read, then an s1 read
      set_ar(0, 1'b1, 32'h7000, 2'd0, 8'd3);
      tick();
      #1 chk("t5_grant", rd_grant_o, 2'b01);
      tick();
      set_ar(0, 1'b0, 32'h0, 2'd0, 8'd0);
      s0_axi_rready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1; m_axi_rlast = 1'b0;
      #1 chk("t5_beat1", s0_axi_rvalid, 1'b1);
      tick();
      m_axi_rdata = 32'h2;
      #1 chk("t5_beat2", s0_axi_rdata, 32'h2);
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_rvalid", s0_axi_rvalid, 1'b0);
      chk("t5_rst_rdata", s0_axi_rdata, 32'h0);
      chk("t5_rst_rready", m_axi_rready, 1'b0);
      chk("t5_rst_grant", rd_grant_o, 2'b00);
      m_axi_rvalid = 1'b0; s0_axi_rready = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      tick();
      set_ar(1, 1'b1, 32'h8000, 2'd3, 8'd0);
      tick();
      #1;
      chk("t5_s1_grant", rd_grant_o, 2'b10);
      chk("t5_s1_araddr", m_axi_araddr, 32'h8000);
      chk("t5_s1_arready", s1_axi_arready, 1'b1);
      chk("t5_s0_arready", s0_axi_arready, 1'b0);
      tick();
      set_ar(1, 1'b0, 32'h0, 2'd0, 8'd0);
      s1_axi_rready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rid = 2'd3; m_axi_rdata = 32'h55; m_axi_rlast = 1'b1;
      #1;
      chk("t5_s1_rvalid", s1_axi_rvalid, 1'b1);
      chk("t5_s1_rid", s1_axi_rid, 2'd3);
      chk("t5_s0_rvalid", s0_axi_rvalid, 1'b0);
      tick();
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s1_axi_rready = 1'b0;
      #1 chk("t5_done", rd_grant_o, 2'b00);

      // 6: B held valid while s0 withholds bready
      set_aw(0, 1'b1, 32'h9000, 2'd1, 8'd0);
      tick();
      #1 chk("t6_grant", wr_grant_o, 2'b01);
      tick();
      set_aw(0, 1'b0, 32'h0, 2'd0, 8'd0);
      set_w(0, 1'b1, 32'h12345678, 1'b1);
      m_axi_wready = 1'b1;
      tick();
      set_w(0, 1'b0, 32'h0, 1'b0);
      m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b1; m_axi_bid = 2'd1; s0_axi_bready = 1'b0;
      repeat (3) begin
         #1;
         chk("t6_bready_low", m_axi_bready, 1'b0);
         chk("t6_grant_hold", wr_grant_o, 2'b01);
         chk("t6_s0_bvalid", s0_axi_bvalid, 1'b1);
         tick();
      end
      s0_axi_bready = 1'b1;
      #1 chk("t6_bready_high", m_axi_bready, 1'b1);
      tick();
      m_axi_bvalid = 1'b0; s0_axi_bready = 1'b0;
      #1 chk("t6_done", wr_grant_o, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
